// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage PC owner, ROM address driver and IF/ID pipeline latch
// Optional HALT-opcode detection is built when FETCH_HALT_EN is defined.
module pc_fetch_unit #(
  parameter int              PC_W        = 11,
  parameter int              INSTR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'h3F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  output logic [PC_W-1:0]    incremento,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               halted
);

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
  logic               rd_valid_q, rd_valid_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]    if_id_pc_plus1_q, if_id_pc_plus1_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               imem_en_c;
  logic               halt_hit;

`ifdef FETCH_HALT_EN
  assign halt_hit = if_id_valid_q && (if_id_instr_q[31:26] == HALT_OPCODE) && !branch_taken;
  assign halted   = (state_q == ST_HALT);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    rd_pc_d          = rd_pc_q;
    rd_valid_d       = rd_valid_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_plus1_d = if_id_pc_plus1_q;
    if_id_valid_d    = if_id_valid_q;
    imem_en_c        = 1'b1;

    if (state_q == ST_HALT) begin
      imem_en_c = 1'b0;
    end else if (branch_taken) begin
      // The ROM word arriving next edge belongs to the old path, so it is marked squashed.
      state_d          = ST_RUN;
      pc_d             = branch_target;
      rd_pc_d          = pc_q;
      rd_valid_d       = 1'b0;
      if_id_instr_d    = imem_rdata;
      if_id_pc_plus1_d = rd_pc_q + PC_ONE;
      if_id_valid_d    = 1'b0;
    end else if (state_q == ST_PRIME) begin
      state_d = ST_RUN;
    end else if (halt_hit) begin
      state_d       = ST_HALT;
      if_id_valid_d = 1'b0;
      imem_en_c     = 1'b0;
    end else if (stall) begin
      state_d   = ST_STALL;
      imem_en_c = 1'b0;
    end else begin
      state_d          = ST_RUN;
      pc_d             = pc_q + PC_ONE;
      rd_pc_d          = pc_q;
      rd_valid_d       = 1'b1;
      if_id_instr_d    = imem_rdata;
      if_id_pc_plus1_d = rd_pc_q + PC_ONE;
      if_id_valid_d    = rd_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_PRIME;
      pc_q             <= RESET_PC;
      rd_pc_q          <= '0;
      rd_valid_q       <= 1'b0;
      if_id_instr_q    <= '0;
      if_id_pc_plus1_q <= '0;
      if_id_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      rd_pc_q          <= rd_pc_d;
      rd_valid_q       <= rd_valid_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus1_q <= if_id_pc_plus1_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign imem_en        = imem_en_c;
  assign incremento     = pc_q + PC_ONE;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus1 = if_id_pc_plus1_q;
  assign if_id_valid    = if_id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit with a queue-based fetch model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [10:0] branch_target;
  logic [31:0] imem_rdata = '0;
  logic [10:0] imem_addr, incremento, if_id_pc_plus1;
  logic        imem_en, if_id_valid, halted;
  logic [31:0] if_id_instr;
  logic        rom_halt_en;

  logic        stall2 = 1'b0, br2 = 1'b0;
  logic [10:0] tgt2 = '0;
  logic [31:0] rdata2 = '0;
  logic [10:0] addr2, incr2, unused_pc1_2;
  logic        en2, unused_valid2, unused_halted2;
  logic [31:0] unused_instr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .imem_en(imem_en), .incremento(incremento), .if_id_instr(if_id_instr),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid), .halted(halted)
  );

  pc_fetch_unit #(.RESET_PC(11'h7FE)) u_dut_wrap (
    .clk(clk), .reset(reset), .stall(stall2), .branch_taken(br2),
    .branch_target(tgt2), .imem_rdata(rdata2), .imem_addr(addr2),
    .imem_en(en2), .incremento(incr2), .if_id_instr(unused_instr2),
    .if_id_pc_plus1(unused_pc1_2), .if_id_valid(unused_valid2), .halted(unused_halted2)
  );

  function automatic logic [31:0] rom_word(input int a, input logic hen);
    if (hen && a == 3) return 32'hFC00_0003;
    return a;
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= rom_word(int'(imem_addr), rom_halt_en);
  always @(posedge clk) if (en2) rdata2 <= rom_word(int'(addr2), 1'b0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: addresses leave the PC into a queue; each advancing cycle the oldest one reaches IF/ID.
  int          m_pc, m_out;
  bit          m_prime, m_halt;
  int          m_q[$];
  logic        e_en, hh;
  logic [31:0] w;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_pc = 0; m_prime = 1; m_halt = 0; m_out = -1;
      m_q = {};
      m_q.push_back(-1);
      chk("rst_instr", if_id_instr, 0);
      chk("rst_pc1", {21'd0, if_id_pc_plus1}, 0);
    end
    hh = 1'b0;
`ifdef FETCH_HALT_EN
    if (!m_halt && m_out >= 0 && !branch_taken && !reset) begin
      w = rom_word(m_out, rom_halt_en);
      hh = (w[31:26] == 6'h3F);
    end
`endif
    if (m_halt) e_en = 1'b0;
    else if (branch_taken || m_prime) e_en = 1'b1;
    else if (hh || stall) e_en = 1'b0;
    else e_en = 1'b1;
    chk("m_addr", {21'd0, imem_addr}, m_pc);
    chk("m_incr", {21'd0, incremento}, (m_pc + 1) % 2048);
    chk("m_en", {31'd0, imem_en}, {31'd0, e_en});
    chk("m_valid", {31'd0, if_id_valid}, (m_out >= 0) ? 1 : 0);
    chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
    if (m_out >= 0) begin
      chk("m_pc1", {21'd0, if_id_pc_plus1}, (m_out + 1) % 2048);
      chk("m_instr", if_id_instr, rom_word(m_out, rom_halt_en));
    end
    if (!reset && !m_halt) begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_prime = 0; m_out = -1;
        m_q = {};
        m_q.push_back(-1);
      end else if (m_prime) m_prime = 0;
      else if (hh) begin m_halt = 1; m_out = -1; end
      else if (!stall) begin
        m_q.push_back(m_pc);
        m_out = m_q.pop_front();
        m_pc = (m_pc + 1) % 2048;
      end
    end
  end

  task automatic wait_pc(input logic [10:0] a);
    for (int k = 0; k < 200; k++) begin
      if (imem_addr == a) break;
      @(posedge clk); #1;
    end
    chk("wait_pc", {21'd0, imem_addr}, {21'd0, a});
  endtask

  logic [10:0] exp_wrap [5];

  initial begin
    reset = 1; stall = 0; branch_taken = 0; branch_target = '0; rom_halt_en = 0;
    exp_wrap = '{11'h7FE, 11'h7FE, 11'h7FF, 11'h000, 11'h001};
    repeat (2) @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wrap_pc", {21'd0, addr2}, {21'd0, exp_wrap[i]});
      if (i == 2) chk("wrap_incr", {21'd0, incr2}, 0);
      if (i >= 3) begin
        chk("t1_valid", {31'd0, if_id_valid}, 1);
        chk("t1_pc1", {21'd0, if_id_pc_plus1}, i - 2);
      end
    end
    @(posedge clk); #1;

    wait_pc(11'd5);
    stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_en", {31'd0, imem_en}, 0);
      chk("stall_pc", {21'd0, imem_addr}, 5);
      chk("stall_pc1", {21'd0, if_id_pc_plus1}, 4);
    end
    @(posedge clk); #1 stall = 0;

    wait_pc(11'd10);
    branch_taken = 1; branch_target = 11'h040;
    @(posedge clk); #1 branch_taken = 0;
    @(negedge clk);
    chk("br_pc", {21'd0, imem_addr}, 32'h40);
    chk("br_bub1", {31'd0, if_id_valid}, 0);
    @(negedge clk);
    chk("br_bub2", {31'd0, if_id_valid}, 0);
    @(negedge clk);
    chk("br_valid", {31'd0, if_id_valid}, 1);
    chk("br_pc1", {21'd0, if_id_pc_plus1}, 32'h41);

    @(posedge clk); #1 stall = 1; branch_taken = 1; branch_target = 11'h100;
    @(posedge clk); #1 branch_taken = 0;
    @(negedge clk);
    chk("brst_pc", {21'd0, imem_addr}, 32'h100);
    chk("brst_valid", {31'd0, if_id_valid}, 0);
    repeat (2) @(posedge clk); #1 stall = 0;

    @(posedge clk); #1 branch_taken = 1; branch_target = 11'h200;
    @(posedge clk); #1 branch_target = 11'h300;
    @(posedge clk); #1 branch_taken = 0;
    repeat (3) @(negedge clk);
    chk("b2b_pc1", {21'd0, if_id_pc_plus1}, 32'h301);

    @(posedge clk); #1 branch_taken = 1; branch_target = 11'h7FD;
    @(posedge clk); #1 branch_taken = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("wrap1_pc", {21'd0, imem_addr}, 32'h7FF);
    chk("wrap1_incr", {21'd0, incremento}, 0);
    repeat (4) begin @(posedge clk); #1; end

    reset = 1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, if_id_valid}, 0);
    chk("midrst_pc", {21'd0, imem_addr}, 0);
    @(posedge clk); #1 reset = 0; branch_taken = 1; branch_target = 11'h020;
    @(posedge clk); #1 branch_taken = 0;
    chk("prime_br_pc", {21'd0, imem_addr}, 32'h20);
    repeat (3) @(negedge clk);
    chk("prime_br_pc1", {21'd0, if_id_pc_plus1}, 32'h21);
    @(posedge clk); #1;

`ifdef FETCH_HALT_EN
    reset = 1; rom_halt_en = 1;
    @(posedge clk); #1 reset = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 1);
    chk("halt_pc", {21'd0, imem_addr}, 5);
    @(posedge clk); #1 branch_taken = 1; branch_target = 11'h040;
    @(posedge clk); #1 branch_taken = 0;
    @(negedge clk);
    chk("halt_ign_br", {21'd0, imem_addr}, 5);
    @(posedge clk); #1 reset = 1; rom_halt_en = 0;
    @(negedge clk);
    chk("halt_rst", {31'd0, halted}, 0);
    @(posedge clk); #1 reset = 0;
    repeat (4) @(posedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
